// File: rtl/pic_controller.sv
// 8-input fixed-priority interrupt controller with edge-triggered requests,
// an in-service register, EOI commands and a programmable vector base.
module pic_controller #(
  parameter logic [11:0] BASE      = 12'h020,
  parameter logic [4:0]  VBASE_RST = 5'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] port,
  input  logic [7:0]  iodin,
  output logic [7:0]  iodout,
  input  logic        iord,
  input  logic        iowr,
  input  logic [7:0]  irq,
  output logic        intr,
  input  logic        inta,
  output logic [7:0]  vector
);

  typedef enum logic {RUN, WAIT_VB} state_t;

  state_t      state, state_nx;
  logic        cs_cmd, cs_data;
  logic [7:0]  irq_d, irr, isr, imr;
  logic [4:0]  vbase, vbase_nx;
  logic        rsel, rsel_nx;
  logic [7:0]  pend, irr_nx, isr_nx, imr_nx;
  logic [3:0]  pn, sn;
  logic        wr_cmd, wr_dat;
  logic        intr_nx;
  logic [7:0]  vector_nx, iodout_nx;

  // Index of the highest-priority set bit; 8 means none set.
  function automatic logic [3:0] lowest(input logic [7:0] v);
    lowest = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest = 4'(i);
  endfunction

  always_comb begin
    pend      = irr & ~imr;
    pn        = lowest(pend);
    sn        = lowest(isr);
    wr_cmd    = cs_cmd & iowr;
    wr_dat    = cs_data & iowr;
    intr_nx   = pn < sn;
    irr_nx    = irr;
    isr_nx    = isr;
    imr_nx    = imr;
    vbase_nx  = vbase;
    rsel_nx   = rsel;
    state_nx  = state;
    vector_nx = vector;
    iodout_nx = 8'hFF;

    unique case (1'b1)
      iord & cs_cmd:  iodout_nx = rsel ? isr : irr;
      iord & cs_data: iodout_nx = imr;
      default:        iodout_nx = 8'hFF;
    endcase

    // EOI clears first so a same-cycle inta on that bit still sets it
    if (wr_cmd) begin
      if (iodin == 8'h20 && !sn[3]) isr_nx[sn[2:0]] = 1'b0;
      if (iodin[7:3] == 5'b01100) isr_nx[iodin[2:0]] = 1'b0;
      if (iodin == 8'h0A) rsel_nx = 1'b0;
      if (iodin == 8'h0B) rsel_nx = 1'b1;
    end

    if (inta) begin
      if (!pn[3]) begin
        irr_nx[pn[2:0]] = 1'b0;
        isr_nx[pn[2:0]] = 1'b1;
        vector_nx       = {vbase, pn[2:0]};
      end else begin
        vector_nx = {vbase, 3'd7};
      end
    end

    irr_nx = irr_nx | (irq & ~irq_d);

    if (wr_cmd && iodin[4]) begin
      irr_nx   = '0;
      isr_nx   = '0;
      imr_nx   = '0;
      state_nx = WAIT_VB;
    end

    if (wr_dat) begin
      unique case (state)
        RUN:     imr_nx = iodin;
        WAIT_VB: begin
          vbase_nx = iodin[7:3];
          state_nx = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_cmd  <= 1'b0;
      cs_data <= 1'b0;
      irq_d   <= '0;
      irr     <= '0;
      isr     <= '0;
      imr     <= '0;
      vbase   <= VBASE_RST;
      rsel    <= 1'b0;
      state   <= RUN;
      intr    <= 1'b0;
      vector  <= '0;
      iodout  <= 8'hFF;
    end else begin
      cs_cmd  <= port == BASE;
      cs_data <= port == BASE + 12'd1;
      irq_d   <= irq;
      irr     <= irr_nx;
      isr     <= isr_nx;
      imr     <= imr_nx;
      vbase   <= vbase_nx;
      rsel    <= rsel_nx;
      state   <= state_nx;
      intr    <= intr_nx;
      vector  <= vector_nx;
      iodout  <= iodout_nx;
    end
  end

endmodule

// File: tb/tb_pic_controller.sv
// Self-checking bench for pic_controller: directed table, hand sequences
// and randomized traffic compared against a behavioural model.
module tb_pic_controller;

  localparam logic [11:0] BASE = 12'h020;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] port;
  logic [7:0]  iodin, iodout, irq, vector;
  logic        iord, iowr, intr, inta;

  int checks = 0;
  int failures = 0;

  pic_controller dut (
    .clk(clk), .reset_n(reset_n), .port(port), .iodin(iodin),
    .iodout(iodout), .iord(iord), .iowr(iowr), .irq(irq),
    .intr(intr), .inta(inta), .vector(vector)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit         m_irr[8], m_isr[8], m_imr[8], m_irqd[8];
  int         m_vbase;
  bit         m_rsel_isr, m_wait, m_sel_cmd, m_sel_dat, m_intr;
  logic [7:0] m_vector, m_iodout;

  function automatic int first_set(input bit v[8]);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic [7:0] pack8(input bit v[8]);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_irr[i] = 0; m_isr[i] = 0; m_imr[i] = 0; m_irqd[i] = 0;
    end
    m_vbase = 1; m_rsel_isr = 0; m_wait = 0;
    m_sel_cmd = 0; m_sel_dat = 0; m_intr = 0;
    m_vector = 8'h00; m_iodout = 8'hFF;
  endtask

  task automatic model_step();
    bit pend[8];
    bit nirr[8];
    bit nisr[8];
    int p, s, idx;
    bit wc, wd;
    for (int i = 0; i < 8; i++) pend[i] = m_irr[i] & ~m_imr[i];
    p = first_set(pend);
    s = first_set(m_isr);
    wc = m_sel_cmd && iowr;
    wd = m_sel_dat && iowr;
    m_intr = p < s;
    if (iord && m_sel_cmd)
      m_iodout = m_rsel_isr ? pack8(m_isr) : pack8(m_irr);
    else if (iord && m_sel_dat)
      m_iodout = pack8(m_imr);
    else
      m_iodout = 8'hFF;
    nirr = m_irr;
    nisr = m_isr;
    if (wc && iodin == 8'h20 && s < 8) nisr[s] = 0;
    if (wc && iodin >= 8'h60 && iodin <= 8'h67) begin
      idx = int'(iodin) - 'h60;
      nisr[idx] = 0;
    end
    if (inta) begin
      if (p < 8) begin
        nirr[p] = 0;
        nisr[p] = 1;
        m_vector = 8'(m_vbase * 8 + p);
      end else begin
        m_vector = 8'(m_vbase * 8 + 7);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (irq[i] && !m_irqd[i]) nirr[i] = 1;
      m_irqd[i] = irq[i];
    end
    if (wc && iodin == 8'h0A) m_rsel_isr = 0;
    if (wc && iodin == 8'h0B) m_rsel_isr = 1;
    if (wc && iodin[4]) begin
      for (int i = 0; i < 8; i++) begin
        nirr[i] = 0; nisr[i] = 0; m_imr[i] = 0;
      end
      m_wait = 1;
    end
    if (wd) begin
      if (m_wait) begin
        m_vbase = int'(iodin) / 8;
        m_wait = 0;
      end else begin
        for (int i = 0; i < 8; i++) m_imr[i] = iodin[i];
      end
    end
    m_irr = nirr;
    m_isr = nisr;
    m_sel_cmd = port == BASE;
    m_sel_dat = port == BASE + 12'd1;
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    check("model_intr", {7'd0, intr}, {7'd0, m_intr});
    check("model_vector", vector, m_vector);
    check("model_iodout", iodout, m_iodout);
  endtask

  task automatic idle();
    port = 12'h000; iowr = 0; iord = 0; inta = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    port = a; iowr = 0; cyc();
    iowr = 1; iodin = d; cyc();
    idle();
  endtask

  task automatic rd(input logic [11:0] a, output logic [7:0] d);
    port = a; iord = 0; cyc();
    iord = 1; cyc();
    d = iodout;
    idle();
  endtask

  task automatic ack(output logic [7:0] v);
    inta = 1; cyc();
    v = vector;
    inta = 0;
  endtask

  typedef struct {
    logic [11:0] port;
    logic [7:0]  din;
    logic        wr, rd, ack;
    logic [7:0]  irq;
    logic        e_intr;
    logic [7:0]  e_vec, e_out;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] v, d;
    int r;

    tbl[0] = '{12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 8'hFF};
    tbl[1] = '{12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 8'hFF};
    tbl[2] = '{12'h000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h08, 8'hFF};
    tbl[3] = '{12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h08, 8'hFF};
    tbl[4] = '{12'h020, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h08, 8'hFF};
    tbl[5] = '{12'h020, 8'h0B, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'h08, 8'hFF};
    tbl[6] = '{12'h020, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'h08, 8'h01};
    tbl[7] = '{12'h020, 8'h20, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 8'h08, 8'hFF};
    tbl[8] = '{12'h020, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 8'h08, 8'h00};

    reset_n = 0; irq = 8'h00; iodin = 8'h00;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_intr", {7'd0, intr}, 8'h00);
    check("rst_vector", vector, 8'h00);
    check("rst_iodout", iodout, 8'hFF);
    reset_n = 1;

    for (int i = 0; i < 9; i++) begin
      port = tbl[i].port; iodin = tbl[i].din; iowr = tbl[i].wr;
      iord = tbl[i].rd; inta = tbl[i].ack; irq = tbl[i].irq;
      cyc();
      check($sformatf("tbl%0d_intr", i), {7'd0, intr}, {7'd0, tbl[i].e_intr});
      check($sformatf("tbl%0d_vec", i), vector, tbl[i].e_vec);
      check($sformatf("tbl%0d_out", i), iodout, tbl[i].e_out);
    end
    idle();

    // Two simultaneous requests, second served only after EOI
    irq = 8'h00; cyc();
    irq = 8'h28; cyc(); cyc();
    check("p35_intr", {7'd0, intr}, 8'h01);
    ack(v); check("p35_vec1", v, 8'h0B);
    cyc(); check("p35_blocked", {7'd0, intr}, 8'h00);
    rd(BASE, d); check("p35_isr08", d, 8'h08);
    wr(BASE, 8'h20);
    rd(BASE, d); check("p35_isr00", d, 8'h00);
    check("p35_intr2", {7'd0, intr}, 8'h01);
    ack(v); check("p35_vec2", v, 8'h0D);
    rd(BASE, d); check("p35_isr20", d, 8'h20);

    // Nesting: higher priority preempts in-service 5
    irq = 8'h2C; cyc(); cyc();
    check("nest_intr", {7'd0, intr}, 8'h01);
    ack(v); check("nest_vec", v, 8'h0A);
    wr(BASE, 8'h20);
    rd(BASE, d); check("nest_eoi", d, 8'h20);
    wr(BASE, 8'h65);
    rd(BASE, d); check("spec_eoi", d, 8'h00);

    // Masking latches but holds off intr
    wr(BASE + 12'd1, 8'h04);
    irq = 8'h28; cyc();
    irq = 8'h2C; cyc(); cyc(); cyc();
    check("mask_intr", {7'd0, intr}, 8'h00);
    wr(BASE, 8'h0A);
    rd(BASE, d); check("mask_irr", d, 8'h04);
    wr(BASE + 12'd1, 8'h00);
    check("unmask_same", {7'd0, intr}, 8'h00);
    cyc(); check("unmask_next", {7'd0, intr}, 8'h01);
    ack(v); check("unmask_vec", v, 8'h0A);
    wr(BASE, 8'h20);

    // Init and new vector base
    wr(BASE, 8'h11);
    wr(BASE + 12'd1, 8'h70);
    irq = 8'h00; cyc();
    irq = 8'h02; cyc(); cyc();
    check("vb_intr", {7'd0, intr}, 8'h01);
    ack(v); check("vb_vec", v, 8'h71);
    rd(BASE + 12'd1, d); check("vb_imr", d, 8'h00);
    wr(BASE, 8'h20);

    // Spurious, level held, unmapped read
    cyc();
    ack(v); check("spur_vec", v, 8'h77);
    wr(BASE, 8'h0B);
    rd(BASE, d); check("spur_isr", d, 8'h00);
    irq = 8'h04;
    repeat (5) cyc();
    ack(v); check("level_vec1", v, 8'h72);
    ack(v); check("level_vec2", v, 8'h77);
    rd(12'h123, d); check("unmapped", d, 8'hFF);

    // EOI and inta in the same cycle
    irq = 8'h06; cyc(); cyc();
    port = BASE; cyc();
    iowr = 1; iodin = 8'h20; inta = 1; cyc();
    check("eoi_ack_vec", vector, 8'h71);
    idle();
    rd(BASE, d); check("eoi_ack_isr", d, 8'h02);

    // Clear and new edge on the same bit
    irq = 8'h0E; cyc();
    irq = 8'h06; cyc();
    irq = 8'h0E; inta = 1; cyc();
    inta = 0;
    check("edge_win_vec", vector, 8'h73);
    wr(BASE, 8'h0A);
    rd(BASE, d); check("edge_win_irr", d, 8'h08);
    wr(BASE, 8'h0B);
    rd(BASE, d); check("edge_win_isr", d, 8'h0A);

    // Reset mid-operation
    @(negedge clk);
    reset_n = 0;
    #1;
    check("mid_rst_intr", {7'd0, intr}, 8'h00);
    check("mid_rst_vec", vector, 8'h00);
    check("mid_rst_out", iodout, 8'hFF);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    cyc(); cyc();
    check("post_rst_intr", {7'd0, intr}, 8'h01);
    ack(v); check("post_rst_vec", v, 8'h09);
    wr(BASE, 8'h20);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) port = BASE;
      else if (r < 8) port = BASE + 12'd1;
      else port = 12'($urandom);
      iowr = $urandom_range(0, 3) == 0;
      iord = $urandom_range(0, 2) == 0;
      inta = $urandom_range(0, 6) == 0;
      if (port == BASE) begin
        case ($urandom_range(0, 9))
          0, 1, 2: iodin = 8'h20;
          3, 4:    iodin = 8'h60 | 8'($urandom_range(0, 7));
          5:       iodin = 8'h0A;
          6:       iodin = 8'h0B;
          7:       iodin = ($urandom_range(0, 3) == 0) ? 8'h13 : 8'h20;
          default: iodin = 8'($urandom);
        endcase
      end else begin
        iodin = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0)
        irq = irq ^ (8'h01 << $urandom_range(0, 7));
      cyc();
    end
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_controller.md
PIC_CONTROLLER -- requirements
Module: pic_controller

Interface
REQ-001 Parameter BASE, default 12'h020: I/O base; command port = BASE, data port = BASE+1.
REQ-002 Parameter VBASE_RST, default 5'h01: reset vector base, giving vectors 08h-0Fh.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 port  input  12  I/O address.
REQ-006 iodin  input  8  I/O write data.
REQ-007 iodout  output  8  registered I/O read data.
REQ-008 iord  input  1  I/O read strobe.
REQ-009 iowr  input  1  I/O write strobe.
REQ-010 irq  input  8  interrupt request lines; bit 0 carries the timer irq0.
REQ-011 intr  output  1  registered interrupt request to the CPU.
REQ-012 inta  input  1  one-cycle interrupt acknowledge from the CPU.
REQ-013 vector  output  8  registered interrupt vector, valid from the cycle after inta.

Function
REQ-014 Address decode shall be registered: cs_cmd/cs_data = (port == BASE / BASE+1) sampled each clock; iowr/iord act together with the registered selects.
REQ-015 Edge detect: irq_d <= irq each cycle; IRR[n] shall set when irq[n] & ~irq_d[n]; IMR does not block latching.
REQ-016 Fixed priority: bit 0 highest, bit 7 lowest.
REQ-017 pend = IRR & ~IMR; intr <= 1 when the highest set bit of pend has higher priority than the highest set bit of ISR (any pend bit counts when ISR = 0); otherwise intr <= 0.
REQ-018 inta cycle with pend != 0, highest pending bit n: IRR[n] <= 0, ISR[n] <= 1, vector <= {vbase, n}.
REQ-019 inta cycle with pend == 0 (spurious): vector <= {vbase, 3'd7}; IRR and ISR unchanged.
REQ-020 Same-cycle inta clear and new edge on the same bit: the edge wins (IRR[n] stays 1); ISR[n] still sets.
REQ-021 Command writes (cs_cmd & iowr):
  - 8'h20: non-specific EOI; clears the highest-priority set ISR bit; no effect if ISR = 0.
  - {5'b01100, n}: specific EOI; clears ISR[n].
  - 8'h0A / 8'h0B: selects IRR / ISR as the command-port read source (rsel).
  - iodin[4] = 1: init; IRR, ISR, IMR <= 0 and init_state <= WAIT_VB.
  - Any other value is ignored.
REQ-022 Data-port state machine, states RUN and WAIT_VB:
  - RUN: data write sets IMR <= iodin.
  - WAIT_VB: data write sets vbase <= iodin[7:3], then the machine goes to RUN.
  - Reads never change state.
REQ-023 Reads: iodout <= the rsel register on cs_cmd, IMR on cs_data, 8'hFF otherwise; update every cycle, one-cycle latency.
REQ-024 EOI and inta in the same cycle: the EOI clear shall apply first, then inta selection uses the pre-cycle ISR for priority; both updates take effect.
REQ-025 Writing IMR shall affect intr from the next cycle; a masked bit already in ISR stays in service until EOI.

Reset
REQ-026 When reset_n = 0, asynchronously: IRR = ISR = 0, IMR = 8'h00, irq_d = 8'h00, vbase = VBASE_RST, rsel = IRR, state = RUN, intr = 0, vector = 8'h00, iodout = 8'hFF, cs_cmd = cs_data = 0.
REQ-027 Reset asserted mid-operation shall discard pending and in-service interrupts; the first rising edge after release shall be latched normally.

Verification
REQ-028 Reset, then irq[0] rises -> intr = 1 two cycles later; inta -> vector = 8'h08, intr = 0, ISR = 8'h01.
REQ-029 irq[3] and irq[5] rise together -> first inta gives 8'h0B; second inta gives 8'h0D only after write 8'h20 to port 020h; ISR goes 08 -> 00 -> 20.
REQ-030 In service 5; irq[2] rises -> intr = 1 (nesting); inta gives 8'h0A; non-specific EOI clears bit 2 only.
REQ-031 Write 8'h04 to 021h, then irq[2] rises -> IRR[2] = 1, intr = 0; write 8'h00 to 021h -> intr = 1 the next cycle.
REQ-032 Write 8'h11 to 020h, 8'h70 to 021h, then irq[1] rises -> inta gives vector 8'h71; read 021h returns 8'h00.
REQ-033 inta with no pending request -> vector = {vbase, 3'd7}, ISR unchanged; irq held high -> IRR sets only once; read of an unmapped port returns 8'hFF.
